// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit
//   Fixed-latency load/store engine behind the load/store queue head, with a
//   word-addressed data memory and a request/grant CDB broadcast for loads.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
    parameter int LATENCY = 3,
    parameter int ADDR_W  = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        require,
    input  logic        opIn,
    input  logic [31:0] baseIn,
    input  logic [31:0] offsetIn,
    input  logic [31:0] writeData,
    input  logic [3:0]  labelIn,
    output logic        available,
    output logic        isLastState,
    output logic        cdbReq,
    input  logic        cdbGrant,
    output logic [3:0]  cdbLabel,
    output logic [31:0] cdbData
);

    localparam int                 c_cnt_w    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_is_load;
    logic [ADDR_W-1:0]   r_word;
    logic [31:0]         r_wdata;
    logic [31:0]         r_result;
    logic [3:0]          r_label;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic [31:0]         w_sum;
    logic                w_last;
    logic                w_wr_en;
    logic                w_unused_addr;

    // Byte-offset bits and bits above the memory depth are dropped so
    // addresses wrap modulo the memory size.
    assign w_sum         = baseIn + offsetIn;
    assign w_unused_addr = ^{w_sum[31:ADDR_W+2], w_sum[1:0]};

    assign w_last  = (r_state == ST_ACCESS) && (r_cnt == '0);
    assign w_wr_en = w_last && !r_is_load && !RST;

    assign available   = (r_state == ST_IDLE);
    assign isLastState = w_last;
    assign cdbReq      = (r_state == ST_WB);
    assign cdbLabel    = cdbReq ? r_label  : 4'd0;
    assign cdbData     = cdbReq ? r_result : 32'd0;

    // Memory contents survive reset; a store aborted by reset never writes.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_word] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_is_load <= 1'b0;
            r_word    <= '0;
            r_wdata   <= 32'd0;
            r_result  <= 32'd0;
            r_label   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (require) begin
                        r_is_load <= opIn;
                        r_word    <= w_sum[ADDR_W+1:2];
                        r_wdata   <= writeData;
                        r_label   <= labelIn;
                        r_cnt     <= c_cnt_load;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (r_is_load) begin
                            r_result <= r_mem[r_word];
                            r_state  <= ST_WB;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WB: begin
                    if (cdbGrant) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit: a LATENCY=3 instance and a LATENCY=1 one.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

    localparam int c_lat = 3;

    logic        clk;
    logic        rst;

    logic        require, opIn, cdbGrant;
    logic [31:0] baseIn, offsetIn, writeData;
    logic [3:0]  labelIn;
    logic        available, isLastState, cdbReq;
    logic [3:0]  cdbLabel;
    logic [31:0] cdbData;

    logic        b_require, b_op, b_grant;
    logic [31:0] b_base, b_off, b_wdata;
    logic [3:0]  b_label;
    logic        b_available, b_last, b_cdbReq;
    logic [3:0]  b_cdbLabel;
    logic [31:0] b_cdbData;

    int n_chk = 0;
    int n_err = 0;

    mem_access_unit #(.LATENCY(c_lat), .ADDR_W(8)) u_dut (
        .clk(clk), .RST(rst), .require(require), .opIn(opIn),
        .baseIn(baseIn), .offsetIn(offsetIn), .writeData(writeData),
        .labelIn(labelIn), .available(available), .isLastState(isLastState),
        .cdbReq(cdbReq), .cdbGrant(cdbGrant), .cdbLabel(cdbLabel), .cdbData(cdbData)
    );

    mem_access_unit #(.LATENCY(1), .ADDR_W(8)) u_dut_l1 (
        .clk(clk), .RST(rst), .require(b_require), .opIn(b_op),
        .baseIn(b_base), .offsetIn(b_off), .writeData(b_wdata),
        .labelIn(b_label), .available(b_available), .isLastState(b_last),
        .cdbReq(b_cdbReq), .cdbGrant(b_grant), .cdbLabel(b_cdbLabel), .cdbData(b_cdbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is in an IDLE cycle T; returns in the cycle the unit is idle again.
    task automatic do_store(input logic [31:0] base, input logic [31:0] off,
                            input logic [31:0] data, input logic [3:0] lbl, input string tag);
        check({tag, ":avail_T"}, {31'd0, available}, 32'd1);
        require = 1'b1; opIn = 1'b0; baseIn = base; offsetIn = off;
        writeData = data; labelIn = lbl;
        for (int k = 1; k <= c_lat; k++) begin
            step();
            // Operands change under the access; the unit must ignore them.
            baseIn = $urandom; writeData = $urandom; opIn = 1'b1; labelIn = 4'h0;
            if (k == c_lat) require = 1'b0;
            check($sformatf("%s:last@T+%0d", tag, k), {31'd0, isLastState}, (k == c_lat) ? 32'd1 : 32'd0);
            check($sformatf("%s:avail@T+%0d", tag, k), {31'd0, available}, 32'd0);
            check($sformatf("%s:req@T+%0d", tag, k), {31'd0, cdbReq}, 32'd0);
        end
        step();
        check({tag, ":avail_done"}, {31'd0, available}, 32'd1);
        check({tag, ":req_done"}, {31'd0, cdbReq}, 32'd0);
        check({tag, ":last_done"}, {31'd0, isLastState}, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] base, input logic [31:0] off,
                           input logic [3:0] lbl, input int delay,
                           input logic [31:0] exp, input string tag);
        check({tag, ":avail_T"}, {31'd0, available}, 32'd1);
        require = 1'b1; opIn = 1'b1; baseIn = base; offsetIn = off;
        labelIn = lbl; cdbGrant = (delay == 0);
        for (int k = 1; k <= c_lat; k++) begin
            step();
            baseIn = $urandom; opIn = 1'b0; labelIn = ~lbl;
            check($sformatf("%s:last@T+%0d", tag, k), {31'd0, isLastState}, (k == c_lat) ? 32'd1 : 32'd0);
            check($sformatf("%s:req@T+%0d", tag, k), {31'd0, cdbReq}, 32'd0);
        end
        step();
        for (int d = 0; d <= delay; d++) begin
            check($sformatf("%s:req_wb%0d", tag, d), {31'd0, cdbReq}, 32'd1);
            check($sformatf("%s:lbl_wb%0d", tag, d), {28'd0, cdbLabel}, {28'd0, lbl});
            check($sformatf("%s:data_wb%0d", tag, d), cdbData, exp);
            check($sformatf("%s:avail_wb%0d", tag, d), {31'd0, available}, 32'd0);
            if (d == delay) begin
                cdbGrant = 1'b1;
                require  = 1'b0;
            end
            step();
        end
        cdbGrant = 1'b0;
        check({tag, ":avail_done"}, {31'd0, available}, 32'd1);
        check({tag, ":req_done"}, {31'd0, cdbReq}, 32'd0);
        check({tag, ":lbl_zero"}, {28'd0, cdbLabel}, 32'd0);
        check({tag, ":data_zero"}, cdbData, 32'd0);
    endtask

    initial begin
        logic [31:0] vals [3];
        rst = 1'b1;
        require = 1'b0; opIn = 1'b0; cdbGrant = 1'b0;
        baseIn = '0; offsetIn = '0; writeData = '0; labelIn = '0;
        b_require = 1'b0; b_op = 1'b0; b_grant = 1'b0;
        b_base = '0; b_off = '0; b_wdata = '0; b_label = '0;

        step();
        step();
        check("rst:avail", {31'd0, available}, 32'd1);
        check("rst:last", {31'd0, isLastState}, 32'd0);
        check("rst:req", {31'd0, cdbReq}, 32'd0);
        check("rst:lbl", {28'd0, cdbLabel}, 32'd0);
        check("rst:data", cdbData, 32'd0);
        check("rst:l1_avail", {31'd0, b_available}, 32'd1);
        rst = 1'b0;
        step();

        do_store(32'h100, 32'h4, 32'hDEADBEEF, 4'hC, "st1");
        do_load(32'h104, 32'h0, 4'hD, 0, 32'hDEADBEEF, "ld_imm");
        do_load(32'h104, 32'h0, 4'hD, 3, 32'hDEADBEEF, "ld_stall");

        do_store(32'hFFFFFFFC, 32'h8, 32'h12345678, 4'h3, "st_wrap");
        do_load(32'h7, 32'h0, 4'h5, 0, 32'h12345678, "ld_align");
        do_load(32'h404, 32'h0, 4'h6, 1, 32'h12345678, "ld_wrap");

        // Reset during a store to word 2 must leave the old contents in place.
        do_store(32'h8, 32'h0, 32'h00000055, 4'h1, "st_pre");
        require = 1'b1; opIn = 1'b0; baseIn = 32'h8; offsetIn = 32'h0;
        writeData = 32'hAAAA0000; labelIn = 4'h2;
        step();
        require = 1'b0;
        check("abort:last_T1", {31'd0, isLastState}, 32'd0);
        step();
        check("abort:last_T2", {31'd0, isLastState}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort:last_T3", {31'd0, isLastState}, 32'd0);
        check("abort:avail_T3", {31'd0, available}, 32'd1);
        check("abort:req_T3", {31'd0, cdbReq}, 32'd0);
        step();
        check("abort:last_T4", {31'd0, isLastState}, 32'd0);
        do_load(32'h8, 32'h0, 4'h7, 0, 32'h00000055, "ld_abort");

        // Reset while a load result waits for grant.
        require = 1'b1; opIn = 1'b1; baseIn = 32'h8; offsetIn = 32'h0; labelIn = 4'h9;
        cdbGrant = 1'b0;
        step();
        require = 1'b0;
        for (int k = 2; k <= c_lat + 1; k++) step();
        check("wbrst:req_before", {31'd0, cdbReq}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wbrst:req_after", {31'd0, cdbReq}, 32'd0);
        check("wbrst:data_after", cdbData, 32'd0);
        check("wbrst:avail_after", {31'd0, available}, 32'd1);
        step();

        // LATENCY=1 instance: store then load of the same word, back to back.
        vals[0] = 32'hCAFEF00D; vals[1] = 32'h0BADC0DE; vals[2] = 32'h13579BDF;
        for (int i = 0; i < 3; i++) begin
            b_require = 1'b1; b_op = 1'b0; b_base = 32'h20; b_off = 32'h0;
            b_wdata = vals[i]; b_label = 4'(i);
            step();
            b_require = 1'b0;
            check($sformatf("l1_st%0d:last_T1", i), {31'd0, b_last}, 32'd1);
            check($sformatf("l1_st%0d:avail_T1", i), {31'd0, b_available}, 32'd0);
            step();
            check($sformatf("l1_st%0d:last_T2", i), {31'd0, b_last}, 32'd0);
            check($sformatf("l1_st%0d:avail_T2", i), {31'd0, b_available}, 32'd1);
            b_require = 1'b1; b_op = 1'b1; b_base = 32'h1C; b_off = 32'h4;
            b_label = 4'(i + 8); b_grant = 1'b1;
            step();
            b_require = 1'b0;
            check($sformatf("l1_ld%0d:last_T1", i), {31'd0, b_last}, 32'd1);
            step();
            check($sformatf("l1_ld%0d:req", i), {31'd0, b_cdbReq}, 32'd1);
            check($sformatf("l1_ld%0d:data", i), b_cdbData, vals[i]);
            check($sformatf("l1_ld%0d:lbl", i), {28'd0, b_cdbLabel}, 32'(i + 8));
            step();
            b_grant = 1'b0;
            check($sformatf("l1_ld%0d:avail", i), {31'd0, b_available}, 32'd1);
            check($sformatf("l1_ld%0d:req_off", i), {31'd0, b_cdbReq}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access unit that sits directly downstream of the load/store queue in the out-of-order core. It accepts the queue-head memory operation when the head is ready, and performs a fixed-latency read or write against an internal word-addressed data memory. It signals the queue on the last access cycle so the head can pop. Load results are broadcast on the CDB under the queue entry's label through a request/grant handshake.

## Interface
- LATENCY, 3: access cycles per operation (≥1)
- ADDR_W, 8: word-index width; memory depth = 2^ADDR_W words of 32 bits
- clk  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- require  in  1  queue head valid and operands ready
- opIn  in  1  1 = load (read), 0 = store (write)
- baseIn  in  32  address operand 1
- offsetIn  in  32  address operand 2
- writeData  in  32  store data
- labelIn  in  4  queue entry id label of the head operation
- available  out  1  unit idle and able to accept (drives queue requireAC)
- isLastState  out  1  high during final access cycle (queue pops on it)
- cdbReq  out  1  load result pending broadcast
- cdbGrant  in  1  CDB arbiter grant for this unit
- cdbLabel  out  4  label of broadcast result
- cdbData  out  32  loaded word

## Operation
- States: IDLE, ACCESS, WB.
- available = (state == IDLE); combinational from state only.
- IDLE: if require && available → latch opIn, addr = baseIn + offsetIn (32-bit, carry-out discarded), writeData, labelIn; load counter with LATENCY−1; go ACCESS. Otherwise stay.
- ACCESS: counter decrements each cycle; isLastState = (state == ACCESS && counter == 0).
  - Last cycle, store: mem[addr[ADDR_W+1:2]] ← latched data at the clock edge; next state IDLE.
  - Last cycle, load: result register ← mem[addr[ADDR_W+1:2]]; next state WB.
- WB: cdbReq = 1, cdbLabel = latched label, cdbData = result. On cdbGrant: next state IDLE. Without grant: hold all outputs stable.
- Address bits [1:0] are ignored (word access only). Bits above ADDR_W+1 are ignored, so addresses wrap modulo memory size.
- Inputs are sampled only at the accept cycle. Changes to require, opIn or the operands during ACCESS/WB are ignored.
- The memory array is not cleared by reset. Read-before-write contents are don't-care.
- cdbLabel and cdbData are 0 whenever cdbReq = 0.

## Timing
- Reset values: state IDLE, available 1, isLastState 0, cdbReq 0, cdbLabel 0, cdbData 0, counter 0.
- Accept in cycle T (IDLE, require = 1).
  - ACCESS occupies T+1 … T+LATENCY.
  - isLastState is high only in T+LATENCY.
- Store: the memory write takes effect at the end of T+LATENCY; available = 1 from T+LATENCY+1. Back-to-back stores occupy LATENCY+1 cycles each.
- Load: cdbReq rises in T+LATENCY+1. If cdbGrant is high in that cycle, available = 1 in T+LATENCY+2. Each cycle of grant delay adds one cycle.
- LATENCY = 1: a single ACCESS cycle, so isLastState is high in T+1.
- A load following a store to the same word reads the new value, because the write completes before the next accept.
- No accept occurs in WB, even if cdbGrant and require are high together. Acceptance resumes in the following IDLE cycle.
- RST mid-ACCESS: the pending store is dropped (no write) and a pending load result is discarded. The unit is IDLE with reset outputs the next cycle.
- RST in WB: cdbReq drops the next cycle and no broadcast occurs.

## Test plan
- Reset then store: RST for 2 cycles. Store base 0x100, offset 0x4, data 0xDEADBEEF, label 4'hC. Required: isLastState high exactly at T+3, available returns at T+4, cdbReq never asserts.
- Load with immediate grant: load base 0x104, offset 0, label 4'hD, cdbGrant tied 1. Required: cdbReq = 1 at T+4 only, cdbLabel 4'hD, cdbData 0xDEADBEEF, available again at T+5.
- Grant stall: same load with cdbGrant held low 3 cycles. Required: cdbReq, cdbLabel and cdbData stay stable for 4 cycles, and require stays high throughout with no new accept.
- Address wrap and alignment:
  - Store to base 0xFFFFFFFC, offset 0x8 (sum 0x4, word 1) with data 0x12345678; load from 0x7 returns 0x12345678.
  - With ADDR_W = 8, a load from 0x404 returns word 1.
- Reset mid-operation: accept a store of 0xAAAA0000 to word 2 (prior value 0x55), assert RST at T+2. Required: later load of word 2 returns 0x55; isLastState never pulses for the aborted access.
- LATENCY = 1 build: alternate store/load to the same word. Required: isLastState pulses at T+1 for each op, and the load returns the just-stored value.
